// File: rtl/vga_scanout.sv
// VGA raster timing generator with a valid/ready pixel input and registered RGB565 output.
// Optional macro VGA_SCANOUT_UNDERFLOW_EN: magenta underflow pixels plus a sticky underflow flag.
module vga_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic [15:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic        pix_sof,
  input  logic        underflow_clr,
  output logic        hsync,
  output logic        vsync,
  output logic        hactive,
  output logic        vactive,
  output logic [4:0]  red,
  output logic [5:0]  green,
  output logic [4:0]  blue,
  output logic        underflow
);

  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(HT);
  localparam int VW = $clog2(VT);

  localparam logic [HW-1:0] H_LAST = HW'(HT - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(VT - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

`ifdef VGA_SCANOUT_UNDERFLOW_EN
  localparam logic [15:0] UF_PIX = {5'd31, 6'd0, 5'd31};
`else
  localparam logic [15:0] UF_PIX = 16'h0000;
`endif

  logic [HW-1:0] hcount;
  logic [VW-1:0] vcount;
  logic          h_vis;
  logic          v_vis;

  assign h_vis     = (hcount < H_ACT);
  assign v_vis     = (vcount < V_ACT);
  assign pix_ready = h_vis && v_vis;
  assign pix_sof   = pix_ready && (hcount == '0) && (vcount == '0);

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      hcount <= '0;
      vcount <= '0;
    end else if (hcount == H_LAST) begin
      hcount <= '0;
      vcount <= (vcount == V_LAST) ? '0 : vcount + 1'b1;
    end else begin
      hcount <= hcount + 1'b1;
    end
  end

  // Outputs describe the counter state of the previous cycle.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      hsync               <= 1'b1;
      vsync               <= 1'b1;
      hactive             <= 1'b0;
      vactive             <= 1'b0;
      {red, green, blue}  <= '0;
    end else begin
      hsync   <= !((hcount >= HS_BEG) && (hcount < HS_END));
      vsync   <= !((vcount >= VS_BEG) && (vcount < VS_END));
      hactive <= h_vis;
      vactive <= v_vis;
      if (pix_ready && pix_valid)
        {red, green, blue} <= pix_data;
      else if (pix_ready)
        {red, green, blue} <= UF_PIX;
      else
        {red, green, blue} <= '0;
    end
  end

`ifdef VGA_SCANOUT_UNDERFLOW_EN
  // A new event outranks a simultaneous clear.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset)
      underflow <= 1'b0;
    else if (pix_ready && !pix_valid)
      underflow <= 1'b1;
    else if (underflow_clr)
      underflow <= 1'b0;
  end
`else
  logic unused_clr;
  assign unused_clr = underflow_clr;
  assign underflow  = 1'b0;
`endif

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout on a reduced raster (16x8 total, 8x4 visible).
module tb_vga_scanout;
  localparam int HTOT = 16;
  localparam int VTOT = 8;
  localparam int FRM  = HTOT * VTOT;

`ifdef VGA_SCANOUT_UNDERFLOW_EN
  localparam logic [15:0] EXP_UF_PIX = 16'hF81F;
  localparam logic        EXP_UF     = 1'b1;
`else
  localparam logic [15:0] EXP_UF_PIX = 16'h0000;
  localparam logic        EXP_UF     = 1'b0;
`endif

  logic        pclk = 1'b0;
  logic        reset;
  logic [15:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic        pix_sof;
  logic        underflow_clr;
  logic        hsync, vsync, hactive, vactive;
  logic [4:0]  red;
  logic [5:0]  green;
  logic [4:0]  blue;
  logic        underflow;

  int tests  = 0;
  int errors = 0;
  int n      = 0;

  vga_scanout #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(2), .V_SYNC(1), .V_BP(1)
  ) dut (
    .pclk(pclk), .reset(reset), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .pix_sof(pix_sof), .underflow_clr(underflow_clr),
    .hsync(hsync), .vsync(vsync), .hactive(hactive), .vactive(vactive),
    .red(red), .green(green), .blue(blue), .underflow(underflow)
  );

  always #5 pclk = ~pclk;

  task automatic tick();
    @(negedge pclk);
    n++;
  endtask

  task automatic goto_pos(input int target);
    for (int i = 0; i < 2 * FRM && (n % FRM) != target; i++) tick();
    tests++;
    if ((n % FRM) != target) begin
      errors++;
      $display("FAIL goto: position %0d required %0d", n % FRM, target);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; pix_valid = 1'b1; pix_data = 16'h0; underflow_clr = 1'b0;
    repeat (3) @(negedge pclk);
    tests++;
    if ({hsync, vsync, hactive, vactive, red, green, blue, underflow} !== {4'b1100, 16'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset_vals: got hs%b vs%b ha%b va%b rgb%h uf%b required hs1 vs1 ha0 va0 rgb0000 uf0",
               hsync, vsync, hactive, vactive, {red, green, blue}, underflow);
    end
    reset = 1'b0;
    n = 0;
    tests++;
    if (pix_sof !== 1'b1 || pix_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_sof: got sof%b rdy%b required 1 1", pix_sof, pix_ready);
    end
  endtask

  task automatic test_ramp();
    int h, v, sof_cnt, act_cnt, hs_low, vs_low, hs_fall, vs_fall;
    logic prev_hs, prev_vs;
    logic [15:0] pd, exp_rgb;
    logic exp_hs, exp_vs, exp_ha, exp_va, exp_rdy, exp_sof;
    sof_cnt = 0; act_cnt = 0; hs_low = 0; vs_low = 0; hs_fall = -1; vs_fall = -1;
    prev_hs = 1'b1; prev_vs = 1'b1;
    for (int k = 0; k < 2 * FRM; k++) begin
      h = n % HTOT;
      v = (n / HTOT) % VTOT;
      exp_rdy = (h < 8) && (v < 4);
      exp_sof = exp_rdy && h == 0 && v == 0;
      tests++;
      if (pix_ready !== exp_rdy || pix_sof !== exp_sof) begin
        errors++;
        $display("FAIL ready_sof h%0d v%0d: got %b%b required %b%b", h, v, pix_ready, pix_sof, exp_rdy, exp_sof);
      end
      if (pix_sof === 1'b1) sof_cnt++;
      pd = {5'(h + v), 6'(4 * h + v), 5'(31 - h)};
      pix_data = pd;
      pix_valid = 1'b1;
      exp_rgb = exp_rdy ? pd : 16'h0;
      exp_hs = !(h >= 10 && h <= 12);
      exp_vs = !(v == 6);
      exp_ha = h < 8;
      exp_va = v < 4;
      tick();
      tests++;
      if ({hsync, vsync, hactive, vactive} !== {exp_hs, exp_vs, exp_ha, exp_va} || {red, green, blue} !== exp_rgb) begin
        errors++;
        $display("FAIL video h%0d v%0d: got sync/act %b%b%b%b rgb %h required %b%b%b%b rgb %h",
                 h, v, hsync, vsync, hactive, vactive, {red, green, blue}, exp_hs, exp_vs, exp_ha, exp_va, exp_rgb);
      end
      if (hactive && vactive) act_cnt++;
      if (!hsync) hs_low++;
      if (!vsync) vs_low++;
      if (prev_hs && !hsync) begin
        if (hs_fall >= 0) begin
          tests++;
          if (n - hs_fall != HTOT) begin
            errors++;
            $display("FAIL hsync_period: got %0d required %0d", n - hs_fall, HTOT);
          end
        end
        hs_fall = n;
      end
      if (prev_vs && !vsync) begin
        if (vs_fall >= 0) begin
          tests++;
          if (n - vs_fall != FRM) begin
            errors++;
            $display("FAIL vsync_period: got %0d required %0d", n - vs_fall, FRM);
          end
        end
        vs_fall = n;
      end
      prev_hs = hsync;
      prev_vs = vsync;
    end
    tests++;
    if (sof_cnt != 2 || act_cnt != 64 || hs_low != 48 || vs_low != 32) begin
      errors++;
      $display("FAIL frame_counts: got sof%0d act%0d hslow%0d vslow%0d required 2 64 48 32",
               sof_cnt, act_cnt, hs_low, vs_low);
    end
    tests++;
    if (vs_fall < 0) begin
      errors++;
      $display("FAIL vsync_seen: got no vsync pulse required one per frame");
    end
    tests++;
    if (underflow !== 1'b0) begin
      errors++;
      $display("FAIL no_underflow: got %b required 0", underflow);
    end
  endtask

  task automatic test_underflow();
    goto_pos(HTOT + 3);
    pix_valid = 1'b0;
    tick();
    pix_valid = 1'b1;
    tests++;
    if ({red, green, blue} !== EXP_UF_PIX || underflow !== EXP_UF) begin
      errors++;
      $display("FAIL underflow_pixel: got rgb %h uf %b required rgb %h uf %b",
               {red, green, blue}, underflow, EXP_UF_PIX, EXP_UF);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++;
      if (underflow !== EXP_UF) begin
        errors++;
        $display("FAIL underflow_sticky: got %b required %b", underflow, EXP_UF);
      end
    end
    underflow_clr = 1'b1;
    tick();
    underflow_clr = 1'b0;
    tests++;
    if (underflow !== 1'b0) begin
      errors++;
      $display("FAIL underflow_clear: got %b required 0", underflow);
    end
  endtask

  task automatic test_set_wins();
    goto_pos(HTOT + 9);
    pix_valid = 1'b0;
    tick();
    pix_valid = 1'b1;
    tests++;
    if (underflow !== 1'b0 || {red, green, blue} !== 16'h0) begin
      errors++;
      $display("FAIL blank_ignore: got uf %b rgb %h required 0 0000", underflow, {red, green, blue});
    end
    goto_pos(3 * HTOT + 2);
    pix_valid = 1'b0;
    underflow_clr = 1'b1;
    tick();
    pix_valid = 1'b1;
    underflow_clr = 1'b0;
    tests++;
    if (underflow !== EXP_UF) begin
      errors++;
      $display("FAIL set_wins: got %b required %b", underflow, EXP_UF);
    end
    underflow_clr = 1'b1;
    tick();
    underflow_clr = 1'b0;
    tests++;
    if (underflow !== 1'b0) begin
      errors++;
      $display("FAIL set_wins_clear: got %b required 0", underflow);
    end
  endtask

  task automatic test_midframe_reset();
    goto_pos(2 * HTOT + 5);
    reset = 1'b1;
    #1;
    tests++;
    if ({hsync, vsync, hactive, vactive, red, green, blue, underflow} !== {4'b1100, 16'h0, 1'b0}
        || pix_sof !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: got hs%b vs%b ha%b va%b rgb%h uf%b sof%b required 1 1 0 0 0000 0 1",
               hsync, vsync, hactive, vactive, {red, green, blue}, underflow, pix_sof);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      tests++;
      if ({hsync, vsync, hactive, vactive, red, green, blue} !== {4'b1100, 16'h0}) begin
        errors++;
        $display("FAIL reset_hold: got hs%b vs%b ha%b va%b rgb%h required 1 1 0 0 0000",
                 hsync, vsync, hactive, vactive, {red, green, blue});
      end
    end
    reset = 1'b0;
    n = 0;
    tests++;
    if (pix_sof !== 1'b1) begin
      errors++;
      $display("FAIL restart_sof: got %b required 1", pix_sof);
    end
    pix_data = 16'h1234;
    pix_valid = 1'b1;
    tick();
    tests++;
    if ({red, green, blue} !== 16'h1234 || hactive !== 1'b1 || vactive !== 1'b1 || pix_sof !== 1'b0) begin
      errors++;
      $display("FAIL restart_first_pixel: got rgb %h ha%b va%b sof%b required 1234 1 1 0",
               {red, green, blue}, hactive, vactive, pix_sof);
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_underflow();
    test_set_wins();
    test_midframe_reset();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
